ss_polar_count: RTL and testbench
=================================

SS_POLAR_COUNT -- requirements
Module: SS_POLAR_COUNT

Interface
REQ-001 Parameter N, default 8: window-length exponent; one window is 2^N enabled cycles.
REQ-002 Parameter SAT_EN, default 1: 1 saturates the accumulator, 0 lets it wrap two's-complement.
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 INIT_N  input  1  reset, synchronous, active-low.
REQ-005 EN  input  1  count enable; low pauses the window and the accumulator.
REQ-006 CLEAR  input  1  synchronous abort of the current window, active-high.
REQ-007 IN  input  1  stochastic magnitude bit from the upstream polar pulse-stretch stage.
REQ-008 SIGN_in  input  1  sign qualifying IN; 0 positive, 1 negative.
REQ-009 VALUE  output  N+1  signed two's-complement count of the last completed window.
REQ-010 VALID  output  1  one-cycle pulse when VALUE updates.
REQ-011 SAT  output  1  set when the last completed window clipped; held with VALUE.
REQ-012 BUSY  output  1  high while a window is partially accumulated (window count nonzero).

Function
REQ-013 Per-cycle delta SHALL be +1 when EN & IN & !SIGN_in, -1 when EN & IN & SIGN_in, otherwise 0.
REQ-014 Accumulator ACC SHALL be N+1 bits signed, representable range -2^N .. 2^N-1.
REQ-015 With SAT_EN=1, ACC+delta above 2^N-1 SHALL hold at 2^N-1 and set an internal clip flag; below -2^N SHALL hold at -2^N and set the clip flag.
REQ-016 With SAT_EN=0, ACC SHALL wrap modulo 2^(N+1) and SAT SHALL stay 0.
REQ-017 Window counter WCNT (N bits) SHALL increment on every cycle with EN=1 and CLEAR=0, wrapping from 2^N-1 to 0.
REQ-018 States: IDLE (WCNT=0, ACC=0) and ACCUM (WCNT nonzero); IDLE->ACCUM on first enabled cycle; ACCUM->IDLE on window end or CLEAR.
REQ-019 Window end is the enabled cycle with WCNT=2^N-1; on that edge VALUE SHALL load ACC+delta (clipped per REQ-015), SAT SHALL load the clip flag including that cycle's clip, ACC and clip flag SHALL clear.
REQ-020 VALID SHALL be high exactly the cycle after the window-end edge; latency from last counted input to VALUE/VALID is 1 cycle.
REQ-021 Back-to-back windows SHALL run with no gap; the cycle after window end is the first cycle of the next window.
REQ-022 EN low SHALL freeze WCNT, ACC and clip flag; IN and SIGN_in SHALL be ignored.
REQ-023 CLEAR high SHALL zero WCNT, ACC and clip flag, leave VALUE and SAT unchanged, and suppress VALID, including when coincident with window end.
REQ-024 VALUE and SAT SHALL hold between VALID pulses.
REQ-025 BUSY SHALL equal (WCNT != 0) as a registered output.

Reset
REQ-026 INIT_N=0 at a rising edge SHALL set WCNT=0, ACC=0, clip flag=0, VALUE=0, SAT=0, VALID=0, BUSY=0, state IDLE.
REQ-027 Reset SHALL take priority over CLEAR and EN; reset mid-window SHALL discard the partial window without a VALID pulse.
REQ-028 The first window after reset release SHALL start on the first cycle with EN=1.

Structure
REQ-029 The state encoding (IDLE, ACCUM) and the default N SHALL live in the shared stochastic package; saturation bounds SHALL be derived from N locally.
REQ-030 A single sub-module SS_SAT_ADD (signed N+1-bit add of a -1/0/+1 delta with clip output, SAT_EN parameter) SHALL be instantiated once.

Verification (N=4, window 16)
REQ-031 EN=1, IN=1, SIGN_in=0 for 16 cycles -> one VALID pulse, VALUE=+15, SAT=1.
REQ-032 EN=1, IN=1 every cycle, SIGN_in alternating 0/1 for 16 cycles -> VALUE=0, SAT=0; IN=1, SIGN_in=1 for 16 cycles -> VALUE=-16, SAT=0.
REQ-033 10 cycles IN=1 SIGN_in=0, EN low 5 cycles, 6 more enabled cycles IN=0 -> VALID 1 cycle after the 16th enabled cycle, VALUE=+10.
REQ-034 CLEAR asserted on the 16th enabled cycle of a window with 7 positive hits -> no VALID, VALUE retains previous value, BUSY=0 next cycle.
REQ-035 INIT_N=0 at cycle 8 of a window with 5 hits, released, then 16 enabled cycles with 3 negative hits -> no VALID before release, then VALUE=-3, VALID once.
REQ-036 SAT_EN=0, 16 cycles of positive hits -> VALUE=-16 (wrapped), SAT=0.

Source files
------------

// File: rtl/ss_polar_count_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ss_polar_count_pkg
//  Description : Shared stochastic package. Holds the window state encoding
//                and the default window-length exponent used by the polar
//                counter and its testbench.
//  Revision    : 1.0  initial release
// ============================================================================
package ss_polar_count_pkg;

    // One window is 2^DEFAULT_N enabled cycles.
    localparam int DEFAULT_N = 8;

    // Window state encoding, 1 bit wide.
    localparam int            STATE_W  = 1;
    localparam logic [STATE_W-1:0] ST_IDLE  = 1'b0;  // WCNT == 0, ACC == 0
    localparam logic [STATE_W-1:0] ST_ACCUM = 1'b1;  // window partially counted

endpackage : ss_polar_count_pkg
`default_nettype wire

// File: rtl/ss_polar_count_if.sv
`default_nettype none
// ============================================================================
//  Module      : ss_polar_count_if
//  Description : Stimulus / result bundle of the polar stochastic counter.
//                master : upstream driver (EN, CLEAR, IN, SIGN_in out;
//                         VALUE, VALID, SAT, BUSY in)
//                slave  : the counter itself (directions reversed)
//  Revision    : 1.0  initial release
// ============================================================================
interface ss_polar_count_if #(
    parameter int N = 8
);
    logic                EN;       // count enable
    logic                CLEAR;    // synchronous abort of the current window
    logic                IN;       // stochastic magnitude bit
    logic                SIGN_in;  // 0 positive, 1 negative
    logic signed [N:0]   VALUE;    // count of the last completed window
    logic                VALID;    // one-cycle pulse when VALUE updates
    logic                SAT;      // last completed window clipped
    logic                BUSY;     // window partially accumulated

    modport master (
        output EN, CLEAR, IN, SIGN_in,
        input  VALUE, VALID, SAT, BUSY
    );

    modport slave (
        input  EN, CLEAR, IN, SIGN_in,
        output VALUE, VALID, SAT, BUSY
    );
endinterface : ss_polar_count_if
`default_nettype wire

// File: rtl/ss_polar_count_sat_add.sv
`default_nettype none
// ============================================================================
//  Module      : ss_sat_add
//  Description : Signed (N+1)-bit add of a -1/0/+1 delta.
//                SAT_EN=1 : result clips to [-2^N, 2^N-1], clip flags it.
//                SAT_EN=0 : result wraps modulo 2^(N+1), clip stays 0.
//  Ports       : a     - signed accumulator value
//                delta - signed 2-bit step (-1, 0, +1)
//                sum   - signed result
//                clip  - high when the result was clipped
//  Revision    : 1.0  initial release
// ============================================================================
module ss_sat_add #(
    parameter int N      = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  wire logic signed [N:0] a,
    input  wire logic signed [1:0] delta,
    output logic signed [N:0]      sum,
    output logic                   clip
);

    generate
        if (SAT_EN) begin : g_sat
            localparam logic signed [N:0] SUM_MAX = {1'b0, {N{1'b1}}};
            localparam logic signed [N:0] SUM_MIN = {1'b1, {N{1'b0}}};

            // One guard bit: overflow shows up as the top two bits differing.
            logic signed [N+1:0] wide;
            assign wide = {a[N], a} + {{N{delta[1]}}, delta};

            always_comb begin
                sum  = wide[N:0];
                clip = 1'b0;
                if (wide[N+1] != wide[N]) begin
                    clip = 1'b1;
                    sum  = wide[N+1] ? SUM_MIN : SUM_MAX;
                end
            end
        end else begin : g_wrap
            assign sum  = a + {{(N-1){delta[1]}}, delta};
            assign clip = 1'b0;
        end
    endgenerate

endmodule : ss_sat_add
`default_nettype wire

// File: rtl/ss_polar_count.sv
`default_nettype none
// ============================================================================
//  Module      : ss_polar_count
//  Description : Polar stochastic counter. Accumulates +1 / -1 for each
//                enabled IN pulse (sign from SIGN_in) over windows of 2^N
//                enabled cycles and publishes the signed window total.
//  Ports       : CLK     - sole clock, rising edge
//                INIT_N  - synchronous active-low reset
//                bus     - slave side of ss_polar_count_if
//                          (EN, CLEAR, IN, SIGN_in in; VALUE, VALID, SAT,
//                          BUSY out)
//  Revision    : 1.0  initial release
// ============================================================================
module ss_polar_count
    import ss_polar_count_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter bit SAT_EN = 1'b1
) (
    input  wire logic       CLK,
    input  wire logic       INIT_N,
    ss_polar_count_if.slave bus
);

    localparam logic [N-1:0] WCNT_LAST = {N{1'b1}};
    localparam logic [N-1:0] WCNT_ONE  = {{(N-1){1'b0}}, 1'b1};

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;

    logic [N-1:0]       wcnt;
    logic signed [N:0]  acc;
    logic               clip_acc;     // any clip seen so far in this window
    logic signed [N:0]  value_q;
    logic               sat_q;
    logic               valid_q;
    logic               busy;

    logic signed [1:0]  delta;
    logic signed [N:0]  sum;
    logic               clip_now;
    logic               count_cycle;  // enabled and not aborted
    logic               win_end;

    // Step for this cycle; CLEAR is handled separately and overrides it.
    assign delta       = (bus.EN && bus.IN) ? (bus.SIGN_in ? 2'sb11 : 2'sb01)
                                            : 2'sb00;
    assign count_cycle = bus.EN && !bus.CLEAR;
    assign win_end     = count_cycle && (wcnt == WCNT_LAST);

    ss_sat_add #(
        .N      (N),
        .SAT_EN (SAT_EN)
    ) u_sat_add (
        .a     (acc),
        .delta (delta),
        .sum   (sum),
        .clip  (clip_now)
    );

    // ------------------------------------------------------------------
    // Window FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!INIT_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Window FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (count_cycle) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (bus.CLEAR || win_end) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Window FSM: outputs. ACCUM tracks WCNT != 0 exactly, so BUSY comes
    // straight from the state register.
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state == ST_ACCUM);
    end

    // ------------------------------------------------------------------
    // Datapath: window counter, accumulator, published result
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!INIT_N) begin
            wcnt     <= '0;
            acc      <= '0;
            clip_acc <= 1'b0;
            value_q  <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.CLEAR) begin
                wcnt     <= '0;
                acc      <= '0;
                clip_acc <= 1'b0;
            end else if (bus.EN) begin
                wcnt <= wcnt + WCNT_ONE;
                if (win_end) begin
                    // Publish the total including this cycle's step.
                    value_q  <= sum;
                    sat_q    <= clip_acc | clip_now;
                    valid_q  <= 1'b1;
                    acc      <= '0;
                    clip_acc <= 1'b0;
                end else begin
                    acc      <= sum;
                    clip_acc <= clip_acc | clip_now;
                end
            end
        end
    end

    assign bus.VALUE = value_q;
    assign bus.VALID = valid_q;
    assign bus.SAT   = sat_q;
    assign bus.BUSY  = busy;

endmodule : ss_polar_count
`default_nettype wire

// File: tb/tb_ss_polar_count.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ss_polar_count
//  Description : Directed testbench for ss_polar_count with N=4. Two
//                instances share the stimulus: one saturating, one wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ss_polar_count;

    localparam int N = 4;

    logic clk;
    logic init_n;

    ss_polar_count_if #(.N(N)) bus_sat  ();
    ss_polar_count_if #(.N(N)) bus_wrap ();

    ss_polar_count #(.N(N), .SAT_EN(1'b1)) u_dut_sat (
        .CLK    (clk),
        .INIT_N (init_n),
        .bus    (bus_sat.slave)
    );

    ss_polar_count #(.N(N), .SAT_EN(1'b0)) u_dut_wrap (
        .CLK    (clk),
        .INIT_N (init_n),
        .bus    (bus_wrap.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;   // VALID pulses seen on the saturating instance

    task automatic check(input string tag, input int observed, input int expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive one clock cycle to both instances, sample #1 after the edge.
    task automatic cyc(input logic en, input logic in, input logic sgn, input logic clr);
        bus_sat.EN       = en;
        bus_sat.IN       = in;
        bus_sat.SIGN_in  = sgn;
        bus_sat.CLEAR    = clr;
        bus_wrap.EN      = en;
        bus_wrap.IN      = in;
        bus_wrap.SIGN_in = sgn;
        bus_wrap.CLEAR   = clr;
        @(posedge clk);
        #1;
        if (bus_sat.VALID === 1'b1) pulses++;
    endtask

    int p0;

    initial begin
        init_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);   // reset beats EN
        check("reset_value", int'(bus_sat.VALUE), 0);
        check("reset_valid", int'(bus_sat.VALID), 0);
        check("reset_sat",   int'(bus_sat.SAT),   0);
        check("reset_busy",  int'(bus_sat.BUSY),  0);
        pulses = 0;

        // 16 positive hits: saturating instance clips at +15.
        init_n = 1'b1;
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("pos_no_early_valid", int'(bus_sat.VALID), 0);
        check("pos_busy",           int'(bus_sat.BUSY),  1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("pos_valid", int'(bus_sat.VALID), 1);
        check("pos_value", int'(bus_sat.VALUE), 15);
        check("pos_sat",   int'(bus_sat.SAT),   1);
        check("pos_busy_end", int'(bus_sat.BUSY), 0);
        check("wrap_value", int'(bus_wrap.VALUE), -16);
        check("wrap_sat",   int'(bus_wrap.SAT),   0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("hold_valid", int'(bus_sat.VALID), 0);
        check("hold_value", int'(bus_sat.VALUE), 15);
        check("hold_sat",   int'(bus_sat.SAT),   1);

        // Alternating signs cancel to zero, then back-to-back all-negative.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, logic'(i % 2), 1'b0);
        check("alt_valid", int'(bus_sat.VALID), 1);
        check("alt_value", int'(bus_sat.VALUE), 0);
        check("alt_sat",   int'(bus_sat.SAT),   0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("neg_valid", int'(bus_sat.VALID), 1);
        check("neg_value", int'(bus_sat.VALUE), -16);
        check("neg_sat",   int'(bus_sat.SAT),   0);
        check("pulse_count_3", pulses, 3);

        // 10 hits, 5-cycle pause with negative IN ignored, 6 empty cycles.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)  cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("pause_busy",  int'(bus_sat.BUSY),  1);
        for (int i = 0; i < 5; i++)  cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("pause_no_early_valid", int'(bus_sat.VALID), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("pause_valid", int'(bus_sat.VALID), 1);
        check("pause_value", int'(bus_sat.VALUE), 10);
        check("pause_wrap_value", int'(bus_wrap.VALUE), 10);

        // CLEAR on the 16th enabled cycle of a window with 7 hits.
        p0 = pulses;
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("clr_valid", int'(bus_sat.VALID), 0);
        check("clr_value", int'(bus_sat.VALUE), 10);
        check("clr_busy",  int'(bus_sat.BUSY),  0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("clr_no_late_valid", pulses - p0, 0);

        // Reset at cycle 8 of a window with 5 hits, then a fresh window.
        p0 = pulses;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        init_n = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("rst_mid_value", int'(bus_sat.VALUE), 0);
        check("rst_mid_busy",  int'(bus_sat.BUSY),  0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_no_valid", pulses - p0, 0);
        init_n = 1'b1;
        for (int i = 0; i < 16; i++)
            cyc(1'b1, logic'(i == 0 || i == 5 || i == 10), 1'b1, 1'b0);
        check("rst_win_valid", int'(bus_sat.VALID), 1);
        check("rst_win_value", int'(bus_sat.VALUE), -3);
        check("rst_win_sat",   int'(bus_sat.SAT),   0);
        check("rst_win_wrap_value", int'(bus_wrap.VALUE), -3);
        check("rst_win_pulses", pulses - p0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_ss_polar_count
`default_nettype wire
